// File: rtl/ahb3lite_pkg.sv
// rtl/ahb3lite_pkg.sv - shared AHB3-Lite transfer-type encodings
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

endpackage

// File: rtl/ahb3lite_arb_select.sv
// rtl/ahb3lite_arb_select.sv - tie-break among equal-priority requesters
// AHB3LITE_ARB_RR_EN: round-robin after last_id; otherwise lowest index wins.
module ahb3lite_arb_select #(
  parameter int MASTERS = 4
) (
  input  logic [MASTERS-1:0]         req,
  input  logic [$clog2(MASTERS)-1:0] last_id,
  output logic [MASTERS-1:0]         win
);

  localparam int IW = $clog2(MASTERS);

`ifdef AHB3LITE_ARB_RR_EN
  // Scan farthest-to-nearest from last_id so the nearest requester overwrites.
  always_comb begin
    logic [IW-1:0] idx;
    win = '0;
    idx = '0;
    for (int k = MASTERS; k >= 1; k--) begin
      idx = IW'((int'(last_id) + k) % MASTERS);
      if (req[idx]) begin
        win      = '0;
        win[idx] = 1'b1;
      end
    end
  end
`else
  logic unused_last_id;
  assign unused_last_id = ^last_id;

  always_comb begin
    win = '0;
    for (int i = MASTERS - 1; i >= 0; i--) begin
      if (req[i]) begin
        win    = '0;
        win[i] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/ahb3lite_slave_arbiter.sv
// rtl/ahb3lite_slave_arbiter.sv - AHB3-Lite slave-side priority arbiter with lock/burst hold
// AHB3LITE_ARB_RR_EN: equal-priority ties resolve round-robin instead of lowest index.
module ahb3lite_slave_arbiter
  import ahb3lite_pkg::*;
#(
  parameter int MASTERS       = 4,
  parameter int PRIORITY_BITS = 2
) (
  input  logic                                  HCLK,
  input  logic                                  HRESETn,
  input  logic [MASTERS-1:0]                    req,
  input  logic [MASTERS-1:0][PRIORITY_BITS-1:0] mst_priority,
  input  logic [MASTERS-1:0]                    mst_HMASTLOCK,
  input  logic [1:0]                            own_HTRANS,
  input  logic                                  HREADY,
  output logic [MASTERS-1:0]                    gnt,
  output logic [$clog2(MASTERS)-1:0]            gnt_id,
  output logic                                  gnt_locked
);

  localparam int IW = $clog2(MASTERS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWNED,
    ST_LOCKED
  } state_t;

  state_t                   state, state_nx;
  logic [IW-1:0]            gnt_id_nx;
  logic [PRIORITY_BITS-1:0] max_pri;
  logic [MASTERS-1:0]       top_req;
  logic [MASTERS-1:0]       win;
  logic [IW-1:0]            win_id;
  logic [IW-1:0]            last_id;
  logic                     own_lock;
  logic                     arb_htrans;
  logic                     do_arb;

  // Only requesters at the highest asserted priority go to the tie-break.
  always_comb begin
    max_pri = '0;
    top_req = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (req[i] && (mst_priority[i] > max_pri)) max_pri = mst_priority[i];
    end
    for (int i = 0; i < MASTERS; i++) begin
      top_req[i] = req[i] && (mst_priority[i] == max_pri);
    end
  end

  ahb3lite_arb_select #(
    .MASTERS(MASTERS)
  ) u_select (
    .req     (top_req),
    .last_id (last_id),
    .win     (win)
  );

  always_comb begin
    win_id = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (win[i]) win_id = IW'(i);
    end
  end

`ifdef AHB3LITE_ARB_RR_EN
  logic [IW-1:0] rr_ptr;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) rr_ptr <= '0;
    else if (do_arb && |req) rr_ptr <= win_id;
  end

  assign last_id = rr_ptr;
`else
  assign last_id = '0;
`endif

  assign own_lock   = mst_HMASTLOCK[gnt_id];
  assign arb_htrans = (own_HTRANS == HTRANS_IDLE) || (own_HTRANS == HTRANS_NONSEQ);

  // Wait states freeze everything; a locked owner only lets go on an IDLE beat.
  always_comb begin
    state_nx  = state;
    gnt_id_nx = gnt_id;
    do_arb    = 1'b0;
    if (HREADY) begin
      case (state)
        ST_LOCKED: do_arb = !own_lock && (own_HTRANS == HTRANS_IDLE);
        ST_OWNED: begin
          if (own_lock) state_nx = ST_LOCKED;
          else          do_arb   = arb_htrans;
        end
        default:   do_arb = arb_htrans;
      endcase
      if (do_arb) begin
        if (|req) begin
          state_nx  = ST_OWNED;
          gnt_id_nx = win_id;
        end else begin
          state_nx  = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= ST_IDLE;
      gnt_id <= '0;
    end else begin
      state  <= state_nx;
      gnt_id <= gnt_id_nx;
    end
  end

  always_comb begin
    gnt         = '0;
    gnt[gnt_id] = 1'b1;
  end

  assign gnt_locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_ahb3lite_slave_arbiter.sv
// tb/tb_ahb3lite_slave_arbiter.sv - self-checking bench for ahb3lite_slave_arbiter
module tb_ahb3lite_slave_arbiter;

  logic            HCLK;
  logic            HRESETn;
  logic [3:0]      req;
  logic [3:0][1:0] mst_priority;
  logic [3:0]      mst_HMASTLOCK;
  logic [1:0]      own_HTRANS;
  logic            HREADY;
  logic [3:0]      gnt;
  logic [1:0]      gnt_id;
  logic            gnt_locked;

  int checks = 0;
  int errors = 0;

  int m_owner  = 0;
  bit m_owned  = 0;
  bit m_locked = 0;

  ahb3lite_slave_arbiter #(
    .MASTERS       (4),
    .PRIORITY_BITS (2)
  ) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .req           (req),
    .mst_priority  (mst_priority),
    .mst_HMASTLOCK (mst_HMASTLOCK),
    .own_HTRANS    (own_HTRANS),
    .HREADY        (HREADY),
    .gnt           (gnt),
    .gnt_id        (gnt_id),
    .gnt_locked    (gnt_locked)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner = highest priority; ties go to the requester nearest after the
  // last owner (round-robin) or to the lowest index.
  function automatic int model_winner(input logic [3:0] r, input logic [3:0][1:0] p, input int last);
    int best     = -1;
    int best_key = -1;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) begin
        int key;
`ifdef AHB3LITE_ARB_RR_EN
        key = int'(p[i]) * 16 + (15 - ((i - last - 1 + 8) % 4));
`else
        key = int'(p[i]) * 16 + (15 - i);
`endif
        if (key > best_key) begin
          best_key = key;
          best     = i;
        end
      end
    end
    return best;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".gnt"}, 32'(gnt), 32'(1 << m_owner));
    chk({tag, ".gnt_id"}, 32'(gnt_id), 32'(m_owner));
    chk({tag, ".gnt_locked"}, 32'(gnt_locked), 32'(m_locked));
    chk({tag, ".onehot"}, 32'($countones(gnt)), 32'd1);
  endtask

  task automatic step(input string tag);
    int n_owner  = m_owner;
    bit n_owned  = m_owned;
    bit n_locked = m_locked;
    bit arb      = 1'b0;
    if (HREADY) begin
      if (m_locked)                               arb = !mst_HMASTLOCK[m_owner] && own_HTRANS == 2'b00;
      else if (m_owned && mst_HMASTLOCK[m_owner]) n_locked = 1'b1;
      else                                        arb = own_HTRANS == 2'b00 || own_HTRANS == 2'b10;
      if (arb) begin
        n_locked = 1'b0;
        if (req != 4'b0000) begin
          n_owner = model_winner(req, mst_priority, m_owner);
          n_owned = 1'b1;
        end else begin
          n_owned = 1'b0;
        end
      end
    end
    @(posedge HCLK);
    #1;
    m_owner  = n_owner;
    m_owned  = n_owned;
    m_locked = n_locked;
    check_outputs(tag);
  endtask

  task automatic pulse_reset(input string tag);
    #2 HRESETn = 1'b0;
    #1;
    m_owner  = 0;
    m_owned  = 1'b0;
    m_locked = 1'b0;
    check_outputs(tag);
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  int rr_exp [4];

  initial begin
    HRESETn       = 1'b0;
    req           = '0;
    mst_priority  = '0;
    mst_HMASTLOCK = '0;
    own_HTRANS    = 2'b00;
    HREADY        = 1'b1;
    #1;
    check_outputs("reset");
    chk("reset.gnt_const", 32'(gnt), 32'h1);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Priority pick: m2 (prio 3) beats m1 (prio 1).
    req = 4'b0110;
    mst_priority[1] = 2'd1;
    mst_priority[2] = 2'd3;
    step("prio");
    chk("prio.gnt_const", 32'(gnt), 32'h4);

    // Burst hold with a higher-priority m3 waiting and the owner dropping req.
    mst_priority = '0;
    mst_priority[2] = 2'd1;
    mst_priority[3] = 2'd3;
    req = 4'b0100; own_HTRANS = 2'b10;
    step("burst_nonseq");
    req = 4'b1100; own_HTRANS = 2'b11;
    step("burst_seq1");
    HREADY = 1'b0;
    step("burst_wait");
    HREADY = 1'b1;
    step("burst_seq2");
    req = 4'b1000;
    step("burst_seq3");
    chk("burst_hold.gnt_const", 32'(gnt), 32'h4);
    own_HTRANS = 2'b00;
    step("burst_end");
    chk("burst_end.gnt_const", 32'(gnt), 32'h8);
    req = 4'b0000;
    step("parked");
    chk("parked.gnt_const", 32'(gnt), 32'h8);

    // Lock plus wait states, then release only on an IDLE unlocked beat.
    req = 4'b0010;
    mst_priority = '0;
    mst_priority[1] = 2'd1;
    mst_priority[3] = 2'd3;
    step("lock_own");
    mst_HMASTLOCK = 4'b0010;
    step("lock_enter");
    chk("lock_enter.locked_const", 32'(gnt_locked), 32'd1);
    req = 4'b1010; HREADY = 1'b0;
    for (int i = 0; i < 3; i++) step("lock_wait");
    chk("lock_wait.gnt_const", 32'(gnt), 32'h2);
    HREADY = 1'b1; own_HTRANS = 2'b11;
    step("lock_seq");
    mst_HMASTLOCK = 4'b0000; own_HTRANS = 2'b10;
    step("lock_nonseq");
    chk("lock_nonseq.gnt_const", 32'(gnt), 32'h2);
    own_HTRANS = 2'b00;
    step("lock_release");
    chk("lock_release.gnt_const", 32'(gnt), 32'h8);

    // Reset in the middle of a lock.
    req = 4'b0010;
    step("relock_own");
    mst_HMASTLOCK = 4'b0010;
    step("relock_enter");
    pulse_reset("reset_mid_lock");
    chk("reset_mid_lock.gnt_const", 32'(gnt), 32'h1);
    mst_HMASTLOCK = 4'b0000;

    // Equal-priority ties from owner 0.
`ifdef AHB3LITE_ARB_RR_EN
    rr_exp = '{1, 2, 3, 0};
`else
    rr_exp = '{0, 0, 0, 0};
`endif
    req = 4'b1111; mst_priority = '0; own_HTRANS = 2'b00; HREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("tie");
      chk("tie.order", 32'(gnt_id), 32'(rr_exp[i]));
    end

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      req          = 4'($urandom);
      mst_priority = 8'($urandom);
      if ($urandom_range(0, 7) == 0) mst_HMASTLOCK = 4'($urandom);
      own_HTRANS   = 2'($urandom);
      HREADY       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) pulse_reset("rand_reset");
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
